// File: rtl/inst_cache_pkg.sv
// inst_cache shared types and constants.
// FSM state, line geometry, address field offsets, counter limit.
package inst_cache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } ic_state_e;

  localparam int LINE_WORDS = 4;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = LINE_WORDS * WORD_W;

  localparam int WORD_LSB   = 2;
  localparam int WORD_SEL_W = 2;
  localparam int INDEX_LSB  = 4;

  localparam logic [15:0] MISS_CNT_MAX = 16'hFFFF;

  function automatic int tag_width(input int idx_w);
    return 32 - INDEX_LSB - idx_w;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/data/valid storage: one write port, one comb read port.
// clr_i wipes all valid bits and beats a same-edge write.
module icache_array
  import inst_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = tag_width(IDX_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [TAG_W-1:0]  wtag_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic              rvalid_o,
  output logic [TAG_W-1:0]  rtag_o,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache with blocking single-line refill.
// Hit in IDLE is combinational; a miss stalls until mem_ack_i.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fetch_en_i,
  input  logic [31:0]              pc_i,
  input  logic                     flush_i,
  output logic [31:0]              instr_o,
  output logic                     stall_o,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  input  logic                     mem_ack_i,
  input  logic [LINE_WORDS*32-1:0] mem_data_i,
  output logic [15:0]              miss_cnt_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = tag_width(IDX_W);

  ic_state_e         state_q, state_d;
  logic [31:0]       addr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [15:0]       miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [WORD_SEL_W-1:0] word;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;

  logic hit, miss, arr_we, arr_clr;
  logic unused_pc_lsb;

  assign idx  = pc_i[INDEX_LSB +: IDX_W];
  assign tag  = pc_i[31 -: TAG_W];
  assign word = pc_i[WORD_LSB +: WORD_SEL_W];

  assign unused_pc_lsb = ^pc_i[1:0];

  assign hit  = (state_q == IDLE) & fetch_en_i
              & rd_valid & (rd_tag == tag);
  assign miss = (state_q == IDLE) & fetch_en_i & ~hit;

  assign arr_we  = (state_q == REFILL) & mem_ack_i;
  assign arr_clr = flush_i
                 & ((state_q == IDLE) | arr_we);

  icache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (arr_clr),
    .we_i     (arr_we),
    .widx_i   (idx_q),
    .wtag_i   (addr_q[31 -: TAG_W]),
    .wdata_i  (mem_data_i),
    .ridx_i   (idx),
    .rvalid_o (rd_valid),
    .rtag_o   (rd_tag),
    .rdata_o  (rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    mem_req_o = 1'b0;
    instr_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          instr_o = rd_data[{word, 5'b0} +: 32];
        end else if (miss) begin
          stall_o = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      addr_q <= '0;
      idx_q  <= '0;
    end else if (miss) begin
      addr_q <= {pc_i[31:4], 4'b0};
      idx_q  <= idx;
    end
  end

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (miss && (miss_cnt_q != MISS_CNT_MAX)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign mem_addr_o = addr_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache.
// Backing memory word at address a holds 32'hA5000000 ^ a.
module tb_inst_cache;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         fetch_en_i;
  logic [31:0]  pc_i;
  logic         flush_i;
  logic [31:0]  instr_o;
  logic         stall_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ack_i;
  logic [127:0] mem_data_i;
  logic [15:0]  miss_cnt_o;

  int checks   = 0;
  int failures = 0;

  inst_cache #(
    .LINES      (16),
    .LINE_WORDS (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .fetch_en_i (fetch_en_i),
    .pc_i       (pc_i),
    .flush_i    (flush_i),
    .instr_o    (instr_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i),
    .miss_cnt_o (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic        fen;
    logic [31:0] instr;
    logic        stall;
    logic        req;
    string       name;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] line(input logic [31:0] a);
    return {32'hA500_0000 ^ (a + 32'd12),
            32'hA500_0000 ^ (a + 32'd8),
            32'hA500_0000 ^ (a + 32'd4),
            32'hA500_0000 ^ a};
  endfunction

  task automatic step;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Fetch pc, ack k cycles after req rises, check delivery.
  task automatic fetch(input string name,
                       input logic [31:0] pc,
                       input int k,
                       input logic [31:0] exp_addr,
                       input logic [31:0] exp_instr,
                       input int exp_stall);
    int  st = 0;
    int  rq = 0;
    bit  done = 0;
    pc_i       = pc;
    fetch_en_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall_o) begin
        done = 1;
        break;
      end
      st++;
      if (mem_req_o) begin
        rq++;
        chk({name, "_addr"}, mem_addr_o, exp_addr);
        if (rq == k + 1) begin
          mem_ack_i  = 1'b1;
          mem_data_i = line(exp_addr);
        end
      end
      step();
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_stall"}, st, exp_stall);
    chk({name, "_instr"}, instr_o, exp_instr);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h100, 1'b1, 32'hA500_0100, 1'b0, 1'b0, "hit_w0"};
    vecs[1] = '{32'h108, 1'b1, 32'hA500_0108, 1'b0, 1'b0, "hit_w2"};
    vecs[2] = '{32'h10C, 1'b1, 32'hA500_010C, 1'b0, 1'b0, "hit_w3"};
    vecs[3] = '{32'h107, 1'b1, 32'hA500_0104, 1'b0, 1'b0, "hit_lsb"};
    vecs[4] = '{32'h104, 1'b0, 32'h0,         1'b0, 1'b0, "fen_off"};
    vecs[5] = '{32'h104, 1'b1, 32'hA500_0104, 1'b0, 1'b0, "hit_w1"};

    rst_i      = 1'b0;
    fetch_en_i = 1'b0;
    pc_i       = '0;
    flush_i    = 1'b0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    @(negedge clk_i);
    step();
    step();
    rst_i = 1'b1;
    #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_cnt", 32'(miss_cnt_o), 32'd0);
    chk("rst_instr", instr_o, 32'h0);

    // Cold miss, ack latency 3
    fetch("cold", 32'h104, 3, 32'h100, 32'hA500_0104, 5);
    chk("cold_cnt", 32'(miss_cnt_o), 32'd1);

    for (int i = 0; i < 6; i++) begin
      pc_i       = vecs[i].pc;
      fetch_en_i = vecs[i].fen;
      #1;
      chk({vecs[i].name, "_instr"}, instr_o, vecs[i].instr);
      chk({vecs[i].name, "_stall"}, 32'(stall_o), 32'(vecs[i].stall));
      chk({vecs[i].name, "_req"}, 32'(mem_req_o), 32'(vecs[i].req));
      step();
    end
    chk("hits_cnt", 32'(miss_cnt_o), 32'd1);

    // Stray ack in IDLE
    pc_i       = 32'h100;
    mem_ack_i  = 1'b1;
    mem_data_i = '1;
    #1;
    chk("stray_ack_instr", instr_o, 32'hA500_0100);
    step();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    #1;
    chk("stray_after_instr", instr_o, 32'hA500_0100);
    chk("stray_after_req", 32'(mem_req_o), 32'd0);

    // Conflict eviction on index 0
    fetch("conf_a", 32'h200, 0, 32'h200, 32'hA500_0200, 2);
    chk("conf_a_cnt", 32'(miss_cnt_o), 32'd2);
    fetch("conf_b", 32'h100, 1, 32'h100, 32'hA500_0100, 3);
    chk("conf_b_cnt", 32'(miss_cnt_o), 32'd3);

    // PC moves and flush without ack during refill
    step();
    pc_i = 32'h310;
    #1;
    chk("mv_miss_stall", 32'(stall_o), 32'd1);
    step();
    pc_i    = 32'h520;
    flush_i = 1'b1;
    #1;
    chk("mv_req", 32'(mem_req_o), 32'd1);
    chk("mv_addr0", mem_addr_o, 32'h310);
    step();
    flush_i    = 1'b0;
    pc_i       = 32'h318;
    mem_ack_i  = 1'b1;
    mem_data_i = line(32'h310);
    #1;
    chk("mv_addr1", mem_addr_o, 32'h310);
    step();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    #1;
    chk("mv_hit_stall", 32'(stall_o), 32'd0);
    chk("mv_hit_instr", instr_o, 32'hA500_0318);
    chk("mv_cnt", 32'(miss_cnt_o), 32'd4);

    // Flush in IDLE: same-cycle lookup still hits
    step();
    pc_i    = 32'h100;
    flush_i = 1'b1;
    #1;
    chk("fl_idle_stall", 32'(stall_o), 32'd0);
    chk("fl_idle_instr", instr_o, 32'hA500_0100);
    step();
    flush_i = 1'b0;
    #1;
    chk("fl_idle_miss", 32'(stall_o), 32'd1);
    step();
    #1;
    chk("fl_req", 32'(mem_req_o), 32'd1);

    // Flush coincident with ack
    flush_i    = 1'b1;
    mem_ack_i  = 1'b1;
    mem_data_i = line(32'h100);
    step();
    flush_i    = 1'b0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    #1;
    chk("fa_remiss", 32'(stall_o), 32'd1);
    chk("fa_idle_req", 32'(mem_req_o), 32'd0);
    step();
    #1;
    chk("fa_req_again", 32'(mem_req_o), 32'd1);
    mem_ack_i  = 1'b1;
    mem_data_i = line(32'h100);
    step();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    #1;
    chk("fa_hit_stall", 32'(stall_o), 32'd0);
    chk("fa_hit_instr", instr_o, 32'hA500_0100);
    chk("fa_cnt", 32'(miss_cnt_o), 32'd6);

    // Reset mid-refill, then late ack
    step();
    pc_i = 32'h500;
    #1;
    chk("rr_miss", 32'(stall_o), 32'd1);
    step();
    #1;
    chk("rr_req", 32'(mem_req_o), 32'd1);
    rst_i = 1'b0;
    step();
    rst_i      = 1'b1;
    fetch_en_i = 1'b0;
    #1;
    chk("rr_req_off", 32'(mem_req_o), 32'd0);
    chk("rr_cnt", 32'(miss_cnt_o), 32'd0);
    chk("rr_addr", mem_addr_o, 32'h0);
    mem_ack_i  = 1'b1;
    mem_data_i = line(32'h500);
    step();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    #1;
    chk("rr_late_req", 32'(mem_req_o), 32'd0);
    chk("rr_late_stall", 32'(stall_o), 32'd0);
    fetch("rr_refetch", 32'h500, 0, 32'h500, 32'hA500_0500, 2);
    chk("rr_refetch_cnt", 32'(miss_cnt_o), 32'd1);

    // Counter saturation
    fetch_en_i = 1'b0;
    force dut.miss_cnt_q = 16'hFFFD;
    step();
    release dut.miss_cnt_q;
    #1;
    chk("sat_preload", 32'(miss_cnt_o), 32'h0000_FFFD);
    fetch("sat1", 32'h600, 0, 32'h600, 32'hA500_0600, 2);
    chk("sat1_cnt", 32'(miss_cnt_o), 32'h0000_FFFE);
    fetch("sat2", 32'h700, 0, 32'h700, 32'hA500_0700, 2);
    chk("sat2_cnt", 32'(miss_cnt_o), 32'h0000_FFFF);
    fetch("sat3", 32'h800, 0, 32'h800, 32'hA500_0800, 2);
    chk("sat3_cnt", 32'(miss_cnt_o), 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
